// File: rtl/draw_arbiter.sv
// Two-requester round-robin front end for a shared circle_lines generator:
// grants one draw command at a time, launches the generator, forwards its points and watches for hangs.
module draw_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               _clock,
    input  logic               _reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_s_x,
    input  logic [2*WIDTH-1:0] req_s_y,
    input  logic [2*WIDTH-1:0] req_height,
    output logic               gen_start,
    output logic [WIDTH-1:0]   gen_s_x,
    output logic [WIDTH-1:0]   gen_s_y,
    output logic [WIDTH-1:0]   gen_height,
    input  logic [WIDTH-1:0]   gen_out0,
    input  logic [WIDTH-1:0]   gen_out1,
    input  logic               gen_valid,
    input  logic               gen_done,
    output logic [WIDTH-1:0]   _out0,
    output logic [WIDTH-1:0]   _out1,
    output logic               _valid,
    output logic               _owner,
    output logic [1:0]         req_done,
    output logic               timeout_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] s_x_q, s_x_d;
    logic [WIDTH-1:0] s_y_q, s_y_d;
    logic [WIDTH-1:0] height_q, height_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic             valid_q, valid_d;
    logic             out_owner_q, out_owner_d;

    logic             grant_any;
    logic             grant_idx;
    logic [WIDTH-1:0] sel_x, sel_y, sel_h;
    logic             height_pos;

    // rr_q names the requester that wins when both are asking.
    assign grant_any  = |req_valid;
    assign grant_idx  = (req_valid == 2'b11) ? rr_q : req_valid[1];
    assign sel_x      = grant_idx ? req_s_x[2*WIDTH-1:WIDTH]    : req_s_x[WIDTH-1:0];
    assign sel_y      = grant_idx ? req_s_y[2*WIDTH-1:WIDTH]    : req_s_y[WIDTH-1:0];
    assign sel_h      = grant_idx ? req_height[2*WIDTH-1:WIDTH] : req_height[WIDTH-1:0];
    assign height_pos = !sel_h[WIDTH-1] && (sel_h != '0);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        s_x_d       = s_x_q;
        s_y_d       = s_y_q;
        height_d    = height_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        valid_d     = 1'b0;
        out_owner_d = out_owner_q;
        req_ready   = 2'b00;

        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted so nothing looks accepted.
                if (grant_any && _reset_n) begin
                    req_ready = grant_idx ? 2'b10 : 2'b01;
                    owner_d   = grant_idx;
                    rr_d      = ~grant_idx;
                    s_x_d     = sel_x;
                    s_y_d     = sel_y;
                    height_d  = sel_h;
                    state_d   = height_pos ? LAUNCH : FINISH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (gen_valid) begin
                    out0_d      = gen_out0;
                    out1_d      = gen_out1;
                    valid_d     = 1'b1;
                    out_owner_d = owner_q;
                end
                if (gen_done) begin
                    state_d = FINISH;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            s_x_q       <= '0;
            s_y_q       <= '0;
            height_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
            valid_q     <= 1'b0;
            out_owner_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            s_x_q       <= s_x_d;
            s_y_q       <= s_y_d;
            height_q    <= height_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            valid_q     <= valid_d;
            out_owner_q <= out_owner_d;
        end
    end

    assign gen_start   = (state_q == LAUNCH);
    assign gen_s_x     = s_x_q;
    assign gen_s_y     = s_y_q;
    assign gen_height  = height_q;
    assign _out0       = out0_q;
    assign _out1       = out1_q;
    assign _valid      = valid_q;
    assign _owner      = out_owner_q;
    assign req_done    = (state_q == FINISH) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign timeout_err = err_q;

endmodule
